// File: rtl/decoder3_8_stream.sv
// Registered 3-to-8 one-hot decoder with a 4-entry code FIFO and a fixed per-word hold time.
// Optional even-parity checking on the input code is enabled by defining DEC_PARITY_EN.
module decoder3_8_stream #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
`ifdef DEC_PARITY_EN
  input  logic       in_par,
`endif
  output logic [7:0] out_onehot,
  output logic       out_valid,
  output logic       busy,
  output logic [2:0] count,
  output logic       err
);

  localparam logic [4:0] HOLD_RELOAD = 5'(HOLD - 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] hold_cnt, hold_cnt_nxt;
  logic [7:0] onehot_nxt;
  logic       valid_nxt;

  logic [2:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic       accept, code_ok, push, pop;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign in_ready = (count != 3'd4) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef DEC_PARITY_EN
  assign code_ok = ~(^{in_code, in_par});
`else
  assign code_ok = 1'b1;
`endif

  assign push = accept && code_ok;
  assign busy = (count != 3'd0) || (state == S_HOLD);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_cnt   <= 5'd0;
      out_onehot <= 8'h00;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      out_onehot <= onehot_nxt;
      out_valid  <= valid_nxt;
    end
  end

  // A finished hold with a non-empty FIFO reloads directly, giving gap-free words.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    onehot_nxt   = out_onehot;
    valid_nxt    = out_valid;
    pop          = 1'b0;
    case (state)
      S_IDLE: begin
        onehot_nxt = 8'h00;
        valid_nxt  = 1'b0;
        if (count != 3'd0) begin
          pop          = 1'b1;
          onehot_nxt   = 8'd1 << mem[rd_ptr];
          valid_nxt    = 1'b1;
          hold_cnt_nxt = HOLD_RELOAD;
          state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt != 5'd0) begin
          hold_cnt_nxt = hold_cnt - 5'd1;
        end else if (count != 3'd0) begin
          pop          = 1'b1;
          onehot_nxt   = 8'd1 << mem[rd_ptr];
          valid_nxt    = 1'b1;
          hold_cnt_nxt = HOLD_RELOAD;
        end else begin
          onehot_nxt = 8'h00;
          valid_nxt  = 1'b0;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef DEC_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err <= 1'b0;
    else if (accept && !code_ok) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder3_8_stream.sv
// Self-checking bench: four decoders (HOLD = 1, 2, 4, 8) share one input stream and are
// compared every cycle against a queue-and-timer reference model, plus directed sequences.
module tb_decoder3_8_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_par;

  logic       rdy [4];
  logic [7:0] oh  [4];
  logic       ov  [4];
  logic       bz  [4];
  logic [2:0] cnt [4];
  logic       er  [4];

`ifdef DEC_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  decoder3_8_stream #(.HOLD(1)) dut_h1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_code(in_code),
`ifdef DEC_PARITY_EN
    .in_par(in_par),
`endif
    .out_onehot(oh[0]), .out_valid(ov[0]), .busy(bz[0]), .count(cnt[0]), .err(er[0]));

  decoder3_8_stream #(.HOLD(2)) dut_h2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_code(in_code),
`ifdef DEC_PARITY_EN
    .in_par(in_par),
`endif
    .out_onehot(oh[1]), .out_valid(ov[1]), .busy(bz[1]), .count(cnt[1]), .err(er[1]));

  decoder3_8_stream #(.HOLD(4)) dut_h4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_code(in_code),
`ifdef DEC_PARITY_EN
    .in_par(in_par),
`endif
    .out_onehot(oh[2]), .out_valid(ov[2]), .busy(bz[2]), .count(cnt[2]), .err(er[2]));

  decoder3_8_stream #(.HOLD(8)) dut_h8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_code(in_code),
`ifdef DEC_PARITY_EN
    .in_par(in_par),
`endif
    .out_onehot(oh[3]), .out_valid(ov[3]), .busy(bz[3]), .count(cnt[3]), .err(er[3]));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a list of waiting codes, the word on display and its remaining cycles.
  logic [2:0] mlist [4][4];
  int         mn    [4];
  int         mcur  [4];
  int         mrem  [4];
  logic       merr  [4];

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [8];

  logic [2:0] full_codes [6];
  logic [7:0] seen_words [8];

  function automatic int holdOf(input int k);
    return 1 << k;
  endfunction

  function automatic logic goodPar(input logic [2:0] c);
    return ^c;
  endfunction

  task automatic checkVal(input string what, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s inst%0d (HOLD=%0d): got %0h expected %0h", what, k, holdOf(k), act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 4; k++) begin
      mn[k]   = 0;
      mcur[k] = -1;
      mrem[k] = 0;
      merr[k] = 1'b0;
    end
  endtask

  task automatic modelStep(input logic v, input logic [2:0] c, input logic p);
    logic acc, good;
    good = PAR_ON ? ((^{c, p}) == 1'b0) : 1'b1;
    for (int k = 0; k < 4; k++) begin
      acc = v && (mn[k] < 4);
      if (mcur[k] >= 0 && mrem[k] > 1) begin
        mrem[k]--;
      end else if (mn[k] > 0) begin
        mcur[k] = int'(mlist[k][0]);
        for (int j = 0; j < 3; j++) mlist[k][j] = mlist[k][j+1];
        mn[k]--;
        mrem[k] = holdOf(k);
      end else begin
        mcur[k] = -1;
      end
      if (acc && good) begin
        mlist[k][mn[k]] = c;
        mn[k]++;
      end
      if (acc && !good) merr[k] = 1'b1;
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 4; k++) begin
      checkVal("onehot", k, int'(oh[k]), (mcur[k] < 0) ? 0 : (1 << mcur[k]));
      checkVal("out_valid", k, int'(ov[k]), int'(mcur[k] >= 0));
      checkVal("busy", k, int'(bz[k]), int'((mn[k] > 0) || (mcur[k] >= 0)));
      checkVal("count", k, int'(cnt[k]), mn[k]);
      checkVal("err", k, int'(er[k]), int'(merr[k]));
      checkVal("in_ready", k, int'(rdy[k]), rst ? 0 : int'(mn[k] < 4));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic p);
    in_valid = v;
    in_code  = c;
    in_par   = p;
    @(posedge clk);
    modelStep(v, c, p);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    rst      = 1'b1;
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    checkOutput();
    rst = 1'b0;
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx, nwords, budget;
    logic saw_full, rb;
    logic [7:0] last;

    rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; in_par = 1'b0;
    modelReset();
    @(negedge clk);
    doReset();

    // Single code 5 on the HOLD=4 decoder.
    applyStimulus(1'b1, 3'd5, goodPar(3'd5));
    checkVal("single_latency", 2, int'(oh[2]), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      checkVal("single_word", 2, int'(oh[2]), 'h20);
      checkVal("single_valid", 2, int'(ov[2]), 1);
    end
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkVal("single_end", 2, int'(oh[2]), 0);
    checkVal("single_busy", 2, int'(bz[2]), 0);
    idle(12);

    // Back-to-back codes 1, 6, 0 on the HOLD=2 decoder.
    doReset();
    tbl[0] = '{1'b1, 3'd1, 8'h00};
    tbl[1] = '{1'b1, 3'd6, 8'h02};
    tbl[2] = '{1'b1, 3'd0, 8'h02};
    tbl[3] = '{1'b0, 3'd0, 8'h40};
    tbl[4] = '{1'b0, 3'd0, 8'h40};
    tbl[5] = '{1'b0, 3'd0, 8'h01};
    tbl[6] = '{1'b0, 3'd0, 8'h01};
    tbl[7] = '{1'b0, 3'd0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].v, tbl[i].c, goodPar(tbl[i].c));
      checkVal("b2b_table", 1, int'(oh[1]), int'(tbl[i].exp));
    end
    idle(30);

    // Backpressure on the HOLD=8 decoder: six codes, the last must wait for a pop.
    doReset();
    full_codes[0] = 3'd7; full_codes[1] = 3'd4; full_codes[2] = 3'd2;
    full_codes[3] = 3'd3; full_codes[4] = 3'd1; full_codes[5] = 3'd6;
    idx = 0; nwords = 0; saw_full = 1'b0; last = 8'h00; budget = 0;
    while ((idx < 6 || bz[3]) && budget < 200) begin
      rb = rdy[3];
      if (!rb && cnt[3] == 3'd4) saw_full = 1'b1;
      if (idx < 6) applyStimulus(1'b1, full_codes[idx], goodPar(full_codes[idx]));
      else         applyStimulus(1'b0, 3'd0, 1'b0);
      if (idx < 6 && rb) idx++;
      if (ov[3] && oh[3] != last && nwords < 8) begin
        seen_words[nwords] = oh[3];
        nwords++;
      end
      last = oh[3];
      budget++;
    end
    checkVal("full_drained", 3, int'(bz[3]), 0);
    checkVal("full_seen", 3, int'(saw_full), 1);
    checkVal("full_nwords", 3, nwords, 6);
    for (int j = 0; j < 6; j++)
      if (j < nwords) checkVal("full_order", 3, int'(seen_words[j]), 1 << full_codes[j]);
    idle(4);

    // Reset during the second cycle of a code-3 hold with two codes queued (HOLD=4).
    doReset();
    applyStimulus(1'b1, 3'd3, goodPar(3'd3));
    applyStimulus(1'b1, 3'd5, goodPar(3'd5));
    applyStimulus(1'b1, 3'd6, goodPar(3'd6));
    checkVal("midhold_word", 2, int'(oh[2]), 'h08);
    checkVal("midhold_count", 2, int'(cnt[2]), 2);
    in_valid = 1'b0;
    rst = 1'b1;
    modelReset();
    #1;
    checkVal("midhold_rst_onehot", 2, int'(oh[2]), 0);
    checkVal("midhold_rst_count", 2, int'(cnt[2]), 0);
    checkVal("midhold_rst_ready", 2, int'(rdy[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("midhold_release_ready", 2, int'(rdy[2]), 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      checkVal("midhold_no_replay", 2, int'(ov[2]), 0);
    end

`ifdef DEC_PARITY_EN
    // Bad parity on code 2 is dropped and flags err; good code 4 is still decoded.
    doReset();
    applyStimulus(1'b1, 3'd2, 1'b0);
    checkVal("par_err_set", 2, int'(er[2]), 1);
    applyStimulus(1'b1, 3'd4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      if (ov[2]) checkVal("par_only_good", 2, int'(oh[2]), 'h10);
      checkVal("par_err_sticky", 2, int'(er[2]), 1);
    end
    doReset();
    checkVal("par_err_cleared", 2, int'(er[2]), 0);
`endif

    // Random traffic, with one reset in the middle.
    doReset();
    for (int i = 0; i < 600; i++) begin
      logic [2:0] c;
      logic p;
      if (i == 300) doReset();
      c = 3'($urandom_range(0, 7));
      p = ($urandom_range(0, 7) == 0) ? ~goodPar(c) : goodPar(c);
      applyStimulus(($urandom_range(0, 3) != 0), c, p);
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
